// File: rtl/rotate_ram_port.sv
// Cornerturn port between the rotating scandoubler and the system RAM controller.
// 16-word write bursts and 8-word read bursts share one word-wide RAM port; rotation is done by address mapping.
module rotate_ram_port #(
    parameter int HCNT_WIDTH = 10,
    parameter int ADDR_WIDTH = 21,
    parameter int WR_BURST   = 16,
    parameter int RD_BURST   = 8,
    parameter int WR_LAT     = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  vidin_req,
    input  logic                  vidin_frame,
    input  logic [HCNT_WIDTH-1:0] vidin_row,
    input  logic [HCNT_WIDTH-1:0] vidin_col,
    input  logic [15:0]           vidin_d,
    output logic                  vidin_ack,
    input  logic                  vidout_req,
    input  logic                  vidout_frame,
    input  logic [HCNT_WIDTH-1:0] vidout_row,
    input  logic [HCNT_WIDTH-1:0] vidout_col,
    output logic [15:0]           vidout_d,
    output logic                  vidout_ack,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_d,
    input  logic                  ram_ack,
    input  logic [15:0]           ram_q,
    input  logic                  ram_valid
);

    localparam int WC_W  = $clog2(WR_BURST + 1);
    localparam int WB_W  = $clog2(WR_BURST);
    localparam int RC_W  = $clog2(RD_BURST + 1);
    localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_GAP
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic                         r_wr_frame;
    logic [HCNT_WIDTH-1:0]        r_wr_row;
    logic [HCNT_WIDTH-WB_W-1:0]   r_wr_col_hi;
    logic [WC_W-1:0]              r_wcnt;
    logic [LAT_W-1:0]             r_lat;
    logic [RC_W-1:0]              r_rcnt;
    logic [15:0]                  r_vidout_d;
    logic                         r_vidout_ack;

    logic [ADDR_WIDTH-1:0]        w_wr_addr;
    logic [ADDR_WIDTH-1:0]        w_rd_addr;
    logic                         w_ram_req;
    logic                         w_ram_we;
    logic [ADDR_WIDTH-1:0]        w_ram_addr;
    logic [15:0]                  w_ram_d;
    logic                         w_vidin_ack;
    logic                         w_unused;

    // Write lands transposed (column-major), read walks row-major: that swap is the rotation.
    assign w_wr_addr = {r_wr_frame, r_wr_col_hi, r_wcnt[WB_W-1:0], r_wr_row};
    assign w_rd_addr = {vidout_frame, vidout_row, vidout_col};
    assign w_unused  = ^vidin_col[WB_W-1:0];

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; writes win arbitration because the video input cannot stall
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = vidin_req ? WR_ISSUE : (vidout_req ? RD_ISSUE : IDLE);
            WR_ISSUE: w_next = ram_ack ? WR_WAIT : WR_ISSUE;
            WR_WAIT: begin
                if (r_lat != {LAT_W{1'b0}}) begin
                    w_next = WR_WAIT;
                end else if (r_wcnt == WC_W'(WR_BURST)) begin
                    w_next = IDLE;
                end else begin
                    w_next = WR_ISSUE;
                end
            end
            RD_ISSUE: w_next = !vidout_req ? IDLE : (ram_ack ? RD_WAIT : RD_ISSUE);
            RD_WAIT:  w_next = ram_valid ? RD_GAP : RD_WAIT;
            RD_GAP:   w_next = (r_rcnt == RC_W'(RD_BURST)) ? IDLE : RD_ISSUE;
            default:  w_next = IDLE;
        endcase
    end

    // RAM-side outputs decoded from state
    always_comb begin
        w_ram_req   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = {ADDR_WIDTH{1'b0}};
        w_ram_d     = 16'h0000;
        w_vidin_ack = 1'b0;
        case (r_state)
            WR_ISSUE: begin
                w_ram_req   = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = w_wr_addr;
                w_ram_d     = vidin_d;
                w_vidin_ack = ram_ack;
            end
            RD_ISSUE: begin
                w_ram_req  = vidout_req;
                w_ram_addr = vidout_req ? w_rd_addr : {ADDR_WIDTH{1'b0}};
            end
            default: begin
                w_ram_req = 1'b0;
            end
        endcase
    end

    // Burst fields, word/latency counters and the registered read return
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_frame   <= 1'b0;
            r_wr_row     <= {HCNT_WIDTH{1'b0}};
            r_wr_col_hi  <= {(HCNT_WIDTH-WB_W){1'b0}};
            r_wcnt       <= {WC_W{1'b0}};
            r_lat        <= {LAT_W{1'b0}};
            r_rcnt       <= {RC_W{1'b0}};
            r_vidout_d   <= 16'h0000;
            r_vidout_ack <= 1'b0;
        end else begin
            r_vidout_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (vidin_req) begin
                        r_wr_frame  <= vidin_frame;
                        r_wr_row    <= vidin_row;
                        r_wr_col_hi <= vidin_col[HCNT_WIDTH-1:WB_W];
                        r_wcnt      <= {WC_W{1'b0}};
                    end else if (vidout_req) begin
                        r_rcnt <= {RC_W{1'b0}};
                    end
                end
                WR_ISSUE: begin
                    if (ram_ack) begin
                        r_wcnt <= r_wcnt + WC_W'(1);
                        r_lat  <= LAT_W'(WR_LAT - 1);
                    end
                end
                WR_WAIT: begin
                    if (r_lat != {LAT_W{1'b0}}) begin
                        r_lat <= r_lat - LAT_W'(1);
                    end else if (r_wcnt == WC_W'(WR_BURST)) begin
                        r_wcnt <= {WC_W{1'b0}};
                    end
                end
                RD_WAIT: begin
                    if (ram_valid) begin
                        r_vidout_d   <= ram_q;
                        r_vidout_ack <= 1'b1;
                        r_rcnt       <= r_rcnt + RC_W'(1);
                    end
                end
                RD_GAP: begin
                    if (r_rcnt == RC_W'(RD_BURST)) begin
                        r_rcnt <= {RC_W{1'b0}};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_req    = w_ram_req;
    assign ram_we     = w_ram_we;
    assign ram_addr   = w_ram_addr;
    assign ram_d      = w_ram_d;
    assign vidin_ack  = w_vidin_ack;
    assign vidout_d   = r_vidout_d;
    assign vidout_ack = r_vidout_ack;

endmodule

// File: tb/tb_rotate_ram_port.sv
// Directed bench for rotate_ram_port: a behavioural RAM, a pixel scoreboard and hand-computed addresses/data.
module tb_rotate_ram_port;

    logic        clk_sys, reset;
    logic        vidin_req, vidin_frame, vidin_ack;
    logic [9:0]  vidin_row, vidin_col;
    logic [15:0] vidin_d;
    logic        vidout_req, vidout_frame, vidout_ack;
    logic [9:0]  vidout_row, vidout_col;
    logic [15:0] vidout_d;
    logic        ram_req, ram_we, ram_ack, ram_valid;
    logic [20:0] ram_addr;
    logic [15:0] ram_d, ram_q;

    rotate_ram_port dut (
        .clk_sys(clk_sys), .reset(reset),
        .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
        .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
        .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
        .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d),
        .ram_ack(ram_ack), .ram_q(ram_q), .ram_valid(ram_valid)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [15:0] mem [logic [20:0]];
    logic [15:0] shadow [logic [20:0]];
    logic [31:0] wlog [$];
    logic [31:0] rlog [$];
    logic [31:0] rd_q [$];
    logic        order [$];
    int rd_pend = 0, rd_delay = 1, valid_cyc = -10, last_vin = -10;
    logic [15:0] rd_data = 16'h0000;
    logic stray_valid = 1'b0;
    int wr_word = 0, rd_target = 0, rd_got = 0;
    logic rd_active = 1'b0, ovr_en = 1'b0;
    logic [15:0] ovr_val = 16'h0000;
    int n_vin = 0, n_vout = 0, excl_viol = 0, gap_viol = 0, lat_viol = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [15:0] wdata(input int k);
        logic [7:0] cb;
        cb = vidin_col[7:0] + 8'(k);
        return ovr_en ? ovr_val : {vidin_frame, vidin_row[6:0], cb};
    endfunction

    function automatic logic [15:0] sb_pix(input logic f, input logic [9:0] y, input logic [9:0] x);
        logic [20:0] key;
        key = {f, y, x};
        return shadow.exists(key) ? shadow[key] : 16'h0000;
    endfunction

    // One clock: inputs settle at negedge, RAM model acts at +1, outputs observed at +2.
    task automatic tick();
        @(negedge clk_sys);
        cyc++;
        #1;
        ram_ack   = 1'b0;
        ram_valid = 1'b0;
        if (rd_pend > 0) begin
            rd_pend--;
            if (rd_pend == 0) begin
                ram_valid = 1'b1;
                ram_q     = rd_data;
                valid_cyc = cyc;
            end
        end
        if (stray_valid) begin
            ram_valid   = 1'b1;
            ram_q       = 16'hDEAD;
            valid_cyc   = cyc;
            stray_valid = 1'b0;
        end
        if (ram_req && (cyc % 2 == 0)) begin
            ram_ack = 1'b1;
            order.push_back(ram_we);
            if (ram_we) begin
                mem[ram_addr] = ram_d;
                wlog.push_back({11'd0, ram_addr});
            end else begin
                rd_pend = rd_delay;
                rd_data = mem.exists(ram_addr) ? mem[ram_addr] : 16'h0000;
                rlog.push_back({11'd0, ram_addr});
            end
        end
        #1;
        if (vidin_ack && vidout_ack) excl_viol++;
        if (vidin_ack) begin
            n_vin++;
            if (cyc - last_vin < 3) gap_viol++;
            last_vin = cyc;
            wr_word++;
            if (wr_word == 16) vidin_req = 1'b0;
            else vidin_d = wdata(wr_word);
        end
        if (vidout_ack) begin
            n_vout++;
            if (cyc != valid_cyc + 1) lat_viol++;
            rd_q.push_back({16'd0, vidout_d});
            if (rd_active) begin
                vidout_col = vidout_col + 10'd1;
                rd_got++;
                if (rd_got == rd_target) begin
                    vidout_req = 1'b0;
                    rd_active  = 1'b0;
                end
            end
        end
    endtask

    task automatic start_write(input logic f, input logic [9:0] row, input logic [9:0] col,
                               input logic oe, input logic [15:0] ov);
        vidin_frame = f;
        vidin_row   = row;
        vidin_col   = col;
        ovr_en      = oe;
        ovr_val     = ov;
        wr_word     = 0;
        for (int k = 0; k < 16; k++) shadow[{f, row, col + 10'(k)}] = wdata(k);
        vidin_d   = wdata(0);
        vidin_req = 1'b1;
    endtask

    task automatic start_read(input logic f, input logic [9:0] row, input logic [9:0] col, input int n);
        vidout_frame = f;
        vidout_row   = row;
        vidout_col   = col;
        rd_target    = n;
        rd_got       = 0;
        rd_active    = 1'b1;
        rd_q.delete();
        vidout_req   = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < bound) begin
            tick();
            n++;
            if (!vidin_req && !vidout_req && !ram_req && rd_pend == 0) quiet++;
            else quiet = 0;
        end
        chk(tag, (quiet < 3) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic clear_logs();
        wlog.delete();
        rlog.delete();
        order.delete();
    endtask

    initial begin
        int nb, n0, n;
        logic exp_w;
        reset = 1'b1;
        vidin_req = 1'b0; vidin_frame = 1'b0; vidin_row = 10'd0; vidin_col = 10'd0; vidin_d = 16'h0000;
        vidout_req = 1'b0; vidout_frame = 1'b0; vidout_row = 10'd0; vidout_col = 10'd0;
        ram_ack = 1'b0; ram_valid = 1'b0; ram_q = 16'h0000;
        repeat (3) tick();
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {11'd0, ram_addr}, 32'd0);
        chk("rst_vidin_ack", {31'd0, vidin_ack}, 32'd0);
        chk("rst_vidout_ack", {31'd0, vidout_ack}, 32'd0);
        chk("rst_vidout_d", {16'd0, vidout_d}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single write burst
        clear_logs();
        n0 = n_vin;
        start_write(1'b0, 10'd5, 10'h020, 1'b0, 16'h0000);
        wait_done("t1_tmo", 400);
        chk("t1_nwr", wlog.size(), 32'd16);
        chk("t1_ack_count", n_vin - n0, 32'd16);
        chk("t1_addr0", qget(wlog, 0), 32'h0000_8005);
        chk("t1_addr15", qget(wlog, 15), 32'h0000_BC05);
        nb = 0;
        for (int k = 0; k < 16; k++) if (qget(wlog, k) != 32'h0000_8005 + 32'(k << 10)) nb++;
        chk("t1_addr_seq", nb, 32'd0);
        chk("t1_data0", {16'd0, mem[21'h08005]}, 32'h0000_0520);
        chk("t1_data15", {16'd0, mem[21'h0BC05]}, 32'h0000_052F);
        chk("t1_gap", gap_viol, 32'd0);

        // 2: four rows, then read rotated row x=1
        for (int r = 0; r < 4; r++) begin
            start_write(1'b0, 10'(r), 10'h000, 1'b0, 16'h0000);
            wait_done("t2_wr_tmo", 400);
        end
        clear_logs();
        start_read(1'b0, 10'd1, 10'd0, 4);
        wait_done("t2_rd_tmo", 400);
        chk("t2_nrd", rd_q.size(), 32'd4);
        chk("t2_px0", qget(rd_q, 0), 32'h0000_0001);
        chk("t2_px1", qget(rd_q, 1), 32'h0000_0101);
        chk("t2_px2", qget(rd_q, 2), 32'h0000_0201);
        chk("t2_px3", qget(rd_q, 3), 32'h0000_0301);
        chk("t2_raddr0", qget(rlog, 0), 32'h0000_0400);
        chk("t2_raddr3", qget(rlog, 3), 32'h0000_0403);

        // 3: simultaneous requests, then a write arriving mid-read
        clear_logs();
        start_write(1'b0, 10'd10, 10'h040, 1'b0, 16'h0000);
        start_read(1'b0, 10'd1, 10'd0, 20);
        n = 0;
        while (rd_got < 3 && n < 2000) begin
            tick();
            n++;
        end
        chk("t3_reach_word3", (rd_got >= 3) ? 32'd1 : 32'd0, 32'd1);
        start_write(1'b0, 10'd12, 10'h000, 1'b0, 16'h0000);
        wait_done("t3_tmo", 3000);
        chk("t3_norder", order.size(), 32'd52);
        nb = 0;
        for (int k = 0; k < 52; k++) begin
            exp_w = (k < 16) || (k >= 24 && k < 40);
            if (k >= order.size() || order[k] != exp_w) nb++;
        end
        chk("t3_order", nb, 32'd0);
        chk("t3_resume_addr", qget(rlog, 8), 32'h0000_0408);
        chk("t3_px12", qget(rd_q, 12), 32'h0000_0C01);
        nb = 0;
        for (int k = 0; k < 20; k++) if (qget(rd_q, k) != {16'd0, sb_pix(1'b0, 10'(k), 10'd1)}) nb++;
        chk("t3_row_data", nb, 32'd0);

        // 4: frame separation
        start_write(1'b0, 10'd20, 10'h010, 1'b1, 16'h1234);
        wait_done("t4_wr0_tmo", 400);
        start_write(1'b1, 10'd20, 10'h010, 1'b1, 16'hABCD);
        wait_done("t4_wr1_tmo", 400);
        start_read(1'b0, 10'h013, 10'd20, 1);
        wait_done("t4_rd0_tmo", 400);
        chk("t4_frame0", qget(rd_q, 0), 32'h0000_1234);
        clear_logs();
        start_read(1'b1, 10'h013, 10'd20, 1);
        wait_done("t4_rd1_tmo", 400);
        chk("t4_frame1", qget(rd_q, 0), 32'h0000_ABCD);
        chk("t4_raddr", qget(rlog, 0), 32'h0010_4C14);

        // 5: reset during the wait after word 7
        start_write(1'b0, 10'd30, 10'h060, 1'b0, 16'h0000);
        n = 0;
        while (wr_word < 7 && n < 500) begin
            tick();
            n++;
        end
        tick();
        reset = 1'b1;
        clear_logs();
        start_write(1'b0, 10'd31, 10'h060, 1'b0, 16'h0000);
        tick();
        chk("t5_req_after_rst", {31'd0, ram_req}, 32'd0);
        chk("t5_ack_after_rst", {31'd0, vidin_ack}, 32'd0);
        chk("t5_no_write_in_rst", wlog.size(), 32'd0);
        reset = 1'b0;
        wait_done("t5_tmo", 400);
        chk("t5_nwr", wlog.size(), 32'd16);
        chk("t5_addr0", qget(wlog, 0), 32'h0001_801F);
        chk("t5_addr15", qget(wlog, 15), 32'h0001_BC1F);

        // 6: slow read return and a stray ram_valid while idle
        rd_delay = 4;
        lat_viol = 0;
        n0 = n_vout;
        start_read(1'b0, 10'h065, 10'd30, 2);
        wait_done("t6_tmo", 400);
        chk("t6_nacks", n_vout - n0, 32'd2);
        chk("t6_px0", qget(rd_q, 0), 32'h0000_1E65);
        chk("t6_px1", qget(rd_q, 1), 32'h0000_1F65);
        chk("t6_ack_latency", lat_viol, 32'd0);
        n0 = n_vout;
        stray_valid = 1'b1;
        repeat (4) tick();
        chk("t6_stray_valid", n_vout - n0, 32'd0);
        rd_delay = 1;

        chk("ack_exclusive", excl_viol, 32'd0);
        chk("write_gap", gap_viol, 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
